operand_read_responder: RTL and testbench

Responder end of the operand read interface: accepts read addresses on the `rd_addr` valid/ready channel and returns the addressed words on the `rd_data` channel. The `rd_data` channel is valid-only. Storage is a small single-ported operand register array with an independent write port, so one write or one read occurs per cycle. The block sits opposite `operand_controller`, drives its `rd_addr_ready_i`, `rd_data_i` and `rd_data_valid_i`, and returns data in request order after a fixed latency.

---
 rtl/config_pkg.sv | 17 +
 rtl/operand_read_responder_delay_pipe.sv | 47 ++++
 rtl/operand_read_responder.sv | 75 +++++++
 tb/tb_operand_read_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared operand-path configuration: address/data word types and read latency.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package config_pkg;

   typedef logic [7:0]  addr_t;
   typedef logic [31:0] data_t;

   // Controller and responder both size their pipelines from this value.
   localparam int unsigned OPERAND_RD_LATENCY = 2;

   // True when an address falls inside an array of num_words entries.
   function automatic logic addr_in_range(input addr_t addr, input int unsigned num_words);
      return 32'(addr) < num_words;
   endfunction

endpackage

// File: rtl/operand_read_responder_delay_pipe.sv
// Fixed-latency {valid, data} shift pipe for responders that cannot stall.
// Latency: DEPTH cycles from vld_i to vld_o.
// Backpressure: none; advances every cycle, data stages load only on valid.
//
// Ports: clk_i/arst_ni clock and async active-low reset; vld_i/dat_i entry
// into stage 0; vld_o/dat_o taken from the last stage.
module delay_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic             vld_i,
   input  logic [WIDTH-1:0] dat_i,
   output logic             vld_o,
   output logic [WIDTH-1:0] dat_o
);

   logic             vld_q [DEPTH];
   logic [WIDTH-1:0] dat_q [DEPTH];

   // Data stages only capture behind a valid bit, so the output word holds
   // its last value across idle cycles instead of shifting stale contents.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= vld_i;
         if (vld_i) begin
            dat_q[0] <= dat_i;
         end
         for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign vld_o = vld_q[DEPTH-1];
   assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/operand_read_responder.sv
// Operand register array answering in-order reads, with an independent write port.
// Latency: READ_LATENCY cycles from read accept to rd_data_valid_o (must be >= 1).
// Backpressure: writes win the single array port and drop rd_addr_ready_o; rd_data is valid-only.
//
// Ports: clk_i/arst_ni clock and async active-low reset; rd_addr_* read request
// channel (valid/ready); rd_data_* response (valid only, one pulse per read);
// wr_en_i/wr_addr_i/wr_data_i write port that never waits.
module operand_read_responder
   import config_pkg::*;
#(
   parameter int unsigned NUM_WORDS    = 16,
   parameter int unsigned READ_LATENCY = OPERAND_RD_LATENCY
) (
   input  logic  clk_i,
   input  logic  arst_ni,
   input  addr_t rd_addr_i,
   input  logic  rd_addr_valid_i,
   output logic  rd_addr_ready_o,
   output data_t rd_data_o,
   output logic  rd_data_valid_o,
   input  logic  wr_en_i,
   input  addr_t wr_addr_i,
   input  data_t wr_data_i
);

   localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   data_t            mem_q [NUM_WORDS];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             rd_accept;
   data_t            rd_word;

   // Ready is held low in reset so nothing is accepted before the first
   // rising edge with reset released.
   assign rd_addr_ready_o = arst_ni & ~wr_en_i;
   assign rd_accept       = rd_addr_valid_i & rd_addr_ready_o;

   assign rd_idx = rd_addr_i[IDX_W-1:0];
   assign wr_idx = wr_addr_i[IDX_W-1:0];

   // Range check uses the full address so out-of-range accesses never alias
   // onto a low-order index.
   always_comb begin
      rd_word = '0;
      if (addr_in_range(rd_addr_i, NUM_WORDS)) begin
         rd_word = mem_q[rd_idx];
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i && addr_in_range(wr_addr_i, NUM_WORDS)) begin
         mem_q[wr_idx] <= wr_data_i;
      end
   end

   // The word is captured at accept time, so later writes cannot disturb
   // a read already in flight.
   delay_pipe #(
      .WIDTH ($bits(data_t)),
      .DEPTH (READ_LATENCY)
   ) u_rd_pipe (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .vld_i   (rd_accept),
      .dat_i   (rd_word),
      .vld_o   (rd_data_valid_o),
      .dat_o   (rd_data_o)
   );

endmodule

// File: tb/tb_operand_read_responder.sv
module tb_operand_read_responder;
   import config_pkg::*;

   logic  clk_i = 1'b0;
   logic  arst_ni;
   addr_t rd_addr_i;
   logic  rd_addr_valid_i;
   logic  rd_addr_ready_o;
   data_t rd_data_o;
   logic  rd_data_valid_o;
   logic  wr_en_i;
   addr_t wr_addr_i;
   data_t wr_data_i;

   operand_read_responder #(
      .NUM_WORDS    (16),
      .READ_LATENCY (2)
   ) dut (
      .clk_i           (clk_i),
      .arst_ni         (arst_ni),
      .rd_addr_i       (rd_addr_i),
      .rd_addr_valid_i (rd_addr_valid_i),
      .rd_addr_ready_o (rd_addr_ready_o),
      .rd_data_o       (rd_data_o),
      .rd_data_valid_o (rd_data_valid_o),
      .wr_en_i         (wr_en_i),
      .wr_addr_i       (wr_addr_i),
      .wr_data_i       (wr_data_i)
   );

   always #5 clk_i = ~clk_i;

   // One record per clock cycle: inputs driven for that cycle and the
   // outputs expected just after they are applied (before the next edge).
   typedef struct {
      logic  we;
      addr_t wa;
      data_t wd;
      logic  rv;
      addr_t ra;
      logic  er;
      logic  ev;
      data_t ed;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input addr_t wa, input data_t wd,
                               input logic rv, input addr_t ra,
                               input logic er, input logic ev, input data_t ed);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd;
      v.rv = rv; v.ra = ra;
      v.er = er; v.ev = ev; v.ed = ed;
      return v;
   endfunction

   function automatic vec_t idle(input logic ev, input data_t ed);
      return mk(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b1, ev, ed);
   endfunction

   function automatic vec_t wr(input addr_t a, input data_t d, input logic ev, input data_t ed);
      return mk(1'b1, a, d, 1'b0, 8'd0, 1'b0, ev, ed);
   endfunction

   function automatic vec_t rd(input addr_t a, input logic ev, input data_t ed);
      return mk(1'b0, 8'd0, 32'h0, 1'b1, a, 1'b1, ev, ed);
   endfunction

   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_i);
         wr_en_i         = vecs[i].we;
         wr_addr_i       = vecs[i].wa;
         wr_data_i       = vecs[i].wd;
         rd_addr_valid_i = vecs[i].rv;
         rd_addr_i       = vecs[i].ra;
         #1;
         check($sformatf("%s[%0d] ready", tag, i), 32'(rd_addr_ready_o), 32'(vecs[i].er));
         check($sformatf("%s[%0d] valid", tag, i), 32'(rd_data_valid_o), 32'(vecs[i].ev));
         if (vecs[i].ev) begin
            check($sformatf("%s[%0d] data", tag, i), rd_data_o, vecs[i].ed);
         end
      end
      @(negedge clk_i);
      wr_en_i         = 1'b0;
      rd_addr_valid_i = 1'b0;
      vecs.delete();
   endtask

   initial begin
      arst_ni         = 1'b0;
      rd_addr_i       = '0;
      rd_addr_valid_i = 1'b0;
      wr_en_i         = 1'b0;
      wr_addr_i       = '0;
      wr_data_i       = '0;

      // Reset held for 3 cycles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check($sformatf("rst[%0d] ready", i), 32'(rd_addr_ready_o), 32'd0);
         check($sformatf("rst[%0d] valid", i), 32'(rd_data_valid_o), 32'd0);
         check($sformatf("rst[%0d] data", i), rd_data_o, 32'd0);
      end
      arst_ni = 1'b1;

      // Reset/idle, write/read, streaming, collision, write-after-accept,
      // out-of-range read and write.
      vecs.push_back(idle(1'b0, 32'h0));                  // 0
      vecs.push_back(rd(8'd5, 1'b0, 32'h0));              // 1
      vecs.push_back(idle(1'b0, 32'h0));                  // 2
      vecs.push_back(idle(1'b1, 32'h0));                  // 3  addr 5 -> 0
      vecs.push_back(wr(8'd3, 32'hDEAD_BEEF, 1'b0, 32'h0));
      vecs.push_back(rd(8'd3, 1'b0, 32'h0));              // 5
      vecs.push_back(idle(1'b0, 32'h0));
      vecs.push_back(idle(1'b1, 32'hDEAD_BEEF));          // 7
      vecs.push_back(wr(8'd0, 32'h10, 1'b0, 32'h0));      // 8
      vecs.push_back(wr(8'd1, 32'h20, 1'b0, 32'h0));
      vecs.push_back(wr(8'd2, 32'h30, 1'b0, 32'h0));
      vecs.push_back(wr(8'd3, 32'h40, 1'b0, 32'h0));
      vecs.push_back(rd(8'd3, 1'b0, 32'h0));              // 12
      vecs.push_back(rd(8'd0, 1'b0, 32'h0));
      vecs.push_back(rd(8'd2, 1'b1, 32'h40));
      vecs.push_back(rd(8'd1, 1'b1, 32'h10));
      vecs.push_back(idle(1'b1, 32'h30));
      vecs.push_back(idle(1'b1, 32'h20));
      vecs.push_back(idle(1'b0, 32'h0));                  // 18
      vecs.push_back(mk(1'b1, 8'd7, 32'h55, 1'b1, 8'd7, 1'b0, 1'b0, 32'h0)); // collision
      vecs.push_back(rd(8'd7, 1'b0, 32'h0));              // 20 accepted now
      vecs.push_back(idle(1'b0, 32'h0));
      vecs.push_back(idle(1'b1, 32'h55));                 // 22
      vecs.push_back(wr(8'd2, 32'h11, 1'b0, 32'h0));      // 23
      vecs.push_back(rd(8'd2, 1'b0, 32'h0));
      vecs.push_back(wr(8'd2, 32'h99, 1'b0, 32'h0));
      vecs.push_back(rd(8'd2, 1'b1, 32'h11));             // 26 old value
      vecs.push_back(idle(1'b0, 32'h0));
      vecs.push_back(idle(1'b1, 32'h99));                 // 28 new value
      vecs.push_back(rd(8'd20, 1'b0, 32'h0));             // 29 out of range
      vecs.push_back(idle(1'b0, 32'h0));
      vecs.push_back(idle(1'b1, 32'h0));                  // 31
      vecs.push_back(wr(8'd20, 32'hAB, 1'b0, 32'h0));     // 32 ignored write
      vecs.push_back(rd(8'd4, 1'b0, 32'h0));              // low bits of 20 alias 4
      vecs.push_back(idle(1'b0, 32'h0));
      vecs.push_back(idle(1'b1, 32'h0));                  // 35
      run_vecs("main");

      // Two reads in flight, then reset right after the second accept edge.
      @(negedge clk_i);
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = 8'd0;
      @(negedge clk_i);
      rd_addr_i       = 8'd1;
      @(posedge clk_i);
      #1;
      arst_ni         = 1'b0;
      rd_addr_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check($sformatf("midrst[%0d] valid", i), 32'(rd_data_valid_o), 32'd0);
         check($sformatf("midrst[%0d] ready", i), 32'(rd_addr_ready_o), 32'd0);
      end
      arst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check($sformatf("postrst[%0d] valid", i), 32'(rd_data_valid_o), 32'd0);
      end

      // Previously written words must read back as zero.
      vecs.push_back(rd(8'd0, 1'b0, 32'h0));
      vecs.push_back(rd(8'd1, 1'b0, 32'h0));
      vecs.push_back(rd(8'd3, 1'b1, 32'h0));
      vecs.push_back(rd(8'd7, 1'b1, 32'h0));
      vecs.push_back(rd(8'd2, 1'b1, 32'h0));
      vecs.push_back(idle(1'b1, 32'h0));
      vecs.push_back(idle(1'b1, 32'h0));
      vecs.push_back(idle(1'b0, 32'h0));
      run_vecs("clr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
